// File: rtl/upower_fetch_decode.sv
// uPower fetch/decode stage: PC, writable word-addressed instruction memory,
// and a registered valid/ready stream of X/XO-format instruction fields.
module upower_fetch_decode #(
    parameter  int IMEM_DEPTH = 256,
    parameter  int PC_W       = 32,
    localparam int AW         = $clog2(IMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            imem_we,
    input  logic [AW-1:0]   imem_waddr,
    input  logic [31:0]     imem_wdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [PC_W-1:0] out_pc,
    output logic [5:0]      PO,
    output logic [4:0]      rs,
    output logic [4:0]      ra,
    output logic [4:0]      rb,
    output logic            OE,
    output logic [8:0]      XO,
    output logic            Rc,
    output logic            halted
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] out_pc_q, out_pc_d;
    logic            out_valid_q, out_valid_d;

    logic [31:0]     imem [IMEM_DEPTH];
    logic [31:0]     fetch_word;
    logic [AW-1:0]   fetch_idx;
    logic [AW-1:0]   next_idx;
    logic [PC_W-1:0] pc_inc;
    logic            advance;
    logic            unused_redirect_lsbs;

    // NOTE: the instruction store has no reset so it maps onto plain RAM;
    // it is loaded by software, and writes must work even while rst_n is low.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    assign fetch_idx  = pc_q[AW+1:2];
    assign fetch_word = imem[fetch_idx];
    assign advance    = !out_valid_q || out_ready;

    // Only the word index wraps; PC bits above the memory window are preserved.
    always_comb begin
        next_idx         = fetch_idx + 1'b1;
        pc_inc           = pc_q;
        pc_inc[AW+1:2]   = next_idx;
    end

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // NOTE: every _d gets a hold default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;

        if (redirect_valid) begin
            out_valid_d = 1'b0;
            pc_d        = {redirect_pc[PC_W-1:2], 2'b00};
            state_d     = S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (advance) begin
                        if (fetch_word[31:26] != 6'd0) begin
                            instr_d     = fetch_word;
                            out_pc_d    = pc_q;
                            out_valid_d = 1'b1;
                            pc_d        = pc_inc;
                        end else begin
                            out_valid_d = 1'b0;
                            state_d     = S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            pc_q        <= '0;
            instr_q     <= '0;
            out_pc_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign PO        = instr_q[31:26];
    assign rs        = instr_q[25:21];
    assign ra        = instr_q[20:16];
    assign rb        = instr_q[15:11];
    assign OE        = instr_q[10];
    assign XO        = instr_q[9:1];
    assign Rc        = instr_q[0];
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_upower_fetch_decode.sv
// Directed bench for upower_fetch_decode: a 256-word instance for stream,
// stall, redirect, halt and write-collision cases, and a 4-word instance for wrap.
module tb_upower_fetch_decode;

    localparam logic [31:0] W0  = 32'h7C221A14;
    localparam logic [31:0] W1  = 32'h7C852050;
    localparam logic [31:0] W2  = 32'h7CA62214;
    localparam logic [31:0] W4  = 32'h7C642A14;
    localparam logic [31:0] W5  = 32'h7D0A4B96;
    localparam logic [31:0] WN  = 32'h7FFF0001;

    logic        clk = 1'b0;
    logic        rst_n, rst_n_w;

    // main instance (256 words)
    logic        imem_we, redirect_valid, out_ready;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata, redirect_pc;
    logic        out_valid, OE, Rc, halted;
    logic [31:0] out_pc;
    logic [5:0]  PO;
    logic [4:0]  rs, ra, rb;
    logic [8:0]  XO;

    // wrap instance (4 words)
    logic        w_imem_we, w_redirect_valid, w_out_ready;
    logic [1:0]  w_imem_waddr;
    logic [31:0] w_imem_wdata, w_redirect_pc;
    logic        w_out_valid, w_OE, w_Rc, w_halted;
    logic [31:0] w_out_pc;
    logic [5:0]  w_PO;
    logic [4:0]  w_rs, w_ra, w_rb;
    logic [8:0]  w_XO;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    upower_fetch_decode #(.IMEM_DEPTH(256), .PC_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
        .PO(PO), .rs(rs), .ra(ra), .rb(rb), .OE(OE), .XO(XO), .Rc(Rc),
        .halted(halted)
    );

    upower_fetch_decode #(.IMEM_DEPTH(4), .PC_W(32)) u_wrap (
        .clk(clk), .rst_n(rst_n_w),
        .imem_we(w_imem_we), .imem_waddr(w_imem_waddr), .imem_wdata(w_imem_wdata),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .out_ready(w_out_ready), .out_valid(w_out_valid), .out_pc(w_out_pc),
        .PO(w_PO), .rs(w_rs), .ra(w_ra), .rb(w_rb), .OE(w_OE), .XO(w_XO), .Rc(w_Rc),
        .halted(w_halted)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_word);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".pc"}, out_pc, exp_pc);
        check({tag, ".word"}, {PO, rs, ra, rb, OE, XO, Rc}, exp_word);
    endtask

    task automatic chk_w(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_word);
        check({tag, ".valid"}, w_out_valid, 1'b1);
        check({tag, ".pc"}, w_out_pc, exp_pc);
        check({tag, ".word"}, {w_PO, w_rs, w_ra, w_rb, w_OE, w_XO, w_Rc}, exp_word);
    endtask

    task automatic chk_halt(input string tag);
        check({tag, ".valid"}, out_valid, 1'b0);
        check({tag, ".halted"}, halted, 1'b1);
    endtask

    task automatic write_main(input logic [7:0] a, input logic [31:0] d);
        imem_we    = 1'b1;
        imem_waddr = a;
        imem_wdata = d;
        tick();
        imem_we    = 1'b0;
    endtask

    task automatic redirect_main(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] wrap_words [4];
        wrap_words[0] = 32'h40000001;
        wrap_words[1] = 32'h44000002;
        wrap_words[2] = 32'h48000003;
        wrap_words[3] = 32'h4C000004;

        rst_n = 1'b0;  rst_n_w = 1'b0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        w_imem_we = 1'b0; w_imem_waddr = '0; w_imem_wdata = '0;
        w_redirect_valid = 1'b0; w_redirect_pc = '0; w_out_ready = 1'b1;

        // program load while both instances are held in reset
        for (int i = 0; i < 4; i++) begin
            w_imem_we    = 1'b1;
            w_imem_waddr = 2'(i);
            w_imem_wdata = wrap_words[i];
            write_main(8'(i), (i == 0) ? W0 : (i == 1) ? W1 : 32'h0);
        end
        w_imem_we = 1'b0;
        write_main(8'd4, W4);
        write_main(8'd5, W5);
        write_main(8'd6, 32'h0);

        check("rst.valid", out_valid, 1'b0);
        check("rst.pc", out_pc, 32'h0);
        check("rst.fields", {PO, rs, ra, rb, OE, XO, Rc}, 32'h0);
        check("rst.halted", halted, 1'b0);

        // basic stream: two instructions then halt marker at index 2
        rst_n = 1'b1;
        tick();
        chk_out("s0", 32'h0, W0);
        check("s0.PO", PO, 6'd31);
        check("s0.rs", rs, 5'd1);
        check("s0.ra", ra, 5'd2);
        check("s0.rb", rb, 5'd3);
        check("s0.OE", OE, 1'b0);
        check("s0.XO", XO, 9'd266);
        check("s0.Rc", Rc, 1'b0);
        tick();
        chk_out("s1", 32'h4, W1);
        check("s1.XO", XO, 9'd40);
        check("s1.rs", rs, 5'd4);
        check("s1.ra", ra, 5'd5);
        check("s1.rb", rb, 5'd4);
        tick();
        chk_halt("h0");
        tick();
        chk_halt("h0.hold");

        // extend program, then resume from HALT and apply backpressure at pc 4
        write_main(8'd2, W2);
        write_main(8'd3, 32'h0);
        chk_halt("h0.after_write");
        redirect_main(32'h0);
        check("resume.valid", out_valid, 1'b0);
        check("resume.halted", halted, 1'b0);
        tick();
        chk_out("bp0", 32'h0, W0);
        tick();
        chk_out("bp1", 32'h4, W1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("bp_stall%0d", i), 32'h4, W1);
        end
        out_ready = 1'b1;
        tick();
        chk_out("bp2", 32'h8, W2);
        tick();
        chk_halt("h1");

        // redirect mid-stream to an unaligned target
        redirect_main(32'h0);
        check("rd.bubble0", out_valid, 1'b0);
        tick();
        chk_out("rd0", 32'h0, W0);
        redirect_main(32'h13);
        check("rd.bubble1", out_valid, 1'b0);
        check("rd.halted", halted, 1'b0);
        tick();
        chk_out("rd1", 32'h10, W4);
        tick();
        chk_out("rd2", 32'h14, W5);
        tick();
        chk_halt("h2");

        // write collision: index 1 written in the cycle it is fetched
        redirect_main(32'h0);
        check("wc.bubble", out_valid, 1'b0);
        tick();
        chk_out("wc0", 32'h0, W0);
        imem_we = 1'b1; imem_waddr = 8'd1; imem_wdata = WN;
        tick();
        imem_we = 1'b0;
        chk_out("wc1.old", 32'h4, W1);
        tick();
        chk_out("wc2", 32'h8, W2);
        tick();
        chk_halt("h3");
        redirect_main(32'h4);
        check("wc.bubble2", out_valid, 1'b0);
        tick();
        chk_out("wc3.new", 32'h4, WN);

        // asynchronous reset while an instruction is presented
        rst_n = 1'b0;
        #1;
        check("arst.valid", out_valid, 1'b0);
        check("arst.pc", out_pc, 32'h0);
        check("arst.fields", {PO, rs, ra, rb, OE, XO, Rc}, 32'h0);
        check("arst.halted", halted, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("arst.restart", 32'h0, W0);

        // wrap on the 4-word instance, then upper PC bits preserved across wrap
        rst_n_w = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_w($sformatf("wrap%0d", i), 32'((i % 4) * 4), wrap_words[i % 4]);
        end
        w_redirect_valid = 1'b1;
        w_redirect_pc    = 32'h106;
        tick();
        w_redirect_valid = 1'b0;
        check("wrap.bubble", w_out_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_w($sformatf("wrap_hi%0d", i), 32'h100 | 32'(((i + 1) % 4) * 4),
                  wrap_words[(i + 1) % 4]);
        end
        check("wrap.halted", w_halted, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
